// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port driven by the UART program loader.
interface uart_prog_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_prog_loader.sv
// UART (8N1) program loader: receives a word-count header plus little-endian
// words and writes them to instruction memory while holding the CPU in reset.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                rx,
  input  logic                load_en,
  uart_prog_loader_if.master  mem,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [15:0]         words_loaded
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CPB_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]   MAX_WORDS = 17'(1 << ADDR_WIDTH);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE, ERR} ld_state_t;

  // ---------------- RX front end ----------------
  logic rx_meta, rx_sync, rx_sync_d;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_d <= 1'b1;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_sync_d <= rx_sync;
    end
  end

  rx_state_t   rstate;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        byte_valid, frame_err;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rstate     <= R_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (rx_sync_d && !rx_sync) begin
            rstate <= R_START;
            cnt    <= '0;
          end
        end
        R_START: begin
          // Mid-bit re-check rejects glitches shorter than half a bit.
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            rstate  <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt == CPB_M1) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) rstate <= R_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt == CPB_M1) begin
            cnt    <= '0;
            rstate <= R_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------- Loader FSM ----------------
  ld_state_t   lstate;
  logic        load_en_d;
  logic [15:0] n_words;
  logic [1:0]  byte_idx;
  logic [31:0] wbuf;

  wire         load_rise  = load_en && !load_en_d;
  wire  [15:0] hdr_n      = {shreg, n_words[7:0]};
  wire  [15:0] words_next = words_loaded + 16'd1;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      lstate        <= IDLE;
      load_en_d     <= 1'b0;
      n_words       <= '0;
      byte_idx      <= '0;
      wbuf          <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_loaded  <= '0;
    end else begin
      load_en_d  <= load_en;
      mem.mem_we <= 1'b0;
      case (lstate)
        IDLE, DONE: begin
          if (load_rise) begin
            lstate       <= HDR0;
            words_loaded <= '0;
            byte_idx     <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
          end
        end
        HDR0: begin
          if (frame_err) begin
            lstate <= ERR;
            error  <= 1'b1;
          end else if (byte_valid) begin
            n_words[7:0] <= shreg;
            lstate       <= HDR1;
          end
        end
        HDR1: begin
          if (frame_err) begin
            lstate <= ERR;
            error  <= 1'b1;
          end else if (byte_valid) begin
            n_words <= hdr_n;
            if (hdr_n == 16'd0) begin
              lstate   <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else if ({1'b0, hdr_n} > MAX_WORDS) begin
              lstate <= ERR;
              error  <= 1'b1;
            end else begin
              lstate <= DATA;
            end
          end
        end
        DATA: begin
          if (frame_err) begin
            // Partial word is dropped; byte_idx restarts on the next load.
            lstate   <= ERR;
            error    <= 1'b1;
            byte_idx <= '0;
          end else if (byte_valid) begin
            if (byte_idx == 2'd3) begin
              mem.mem_we    <= 1'b1;
              mem.mem_addr  <= words_loaded[ADDR_WIDTH-1:0];
              mem.mem_wdata <= {shreg, wbuf[23:0]};
              words_loaded  <= words_next;
              byte_idx      <= '0;
              if (words_next == n_words) begin
                lstate   <= DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end
            end else begin
              wbuf[8*byte_idx +: 8] <= shreg;
              byte_idx              <= byte_idx + 1'b1;
            end
          end
        end
        ERR: begin
          if (!load_en) begin
            lstate   <= IDLE;
            error    <= 1'b0;
            cpu_hold <= 1'b0;
          end
        end
        default: lstate <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

- Receives a program image over UART and writes it word-by-word into instruction memory.
- Holds the CPU in reset while loading, then releases it.
- Sits between the board RX pin and the instruction-memory write port, alongside `top`.
- Lets a host reload programs without resynthesis.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 4.
- ADDR_WIDTH, 14, instruction-memory word-address width.
- clock  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  UART serial input: idle high, 8N1, LSB first; asynchronous to `clock`.
- load_en  in  1  level; a rising edge (sampled) while IDLE or DONE starts a load.
- mem_we  out  1  one-cycle instruction-memory write strobe.
- mem_addr  out  ADDR_WIDTH  word address for `mem_we`.
- mem_wdata  out  32  write data for `mem_we`.
- cpu_hold  out  1  high while loading or in error; drives the CPU reset.
- done  out  1  high in DONE until the next load starts or reset.
- error  out  1  high in ERR until `load_en` is low, then returns to IDLE.
- words_loaded  out  16  words written in the current or last load.

## Operation
- **RX front end**
  - `rx` passes through a 2-FF synchronizer.
  - A falling edge of the synchronized rx while the receiver is idle starts a frame.
  - Start bit is re-sampled at CLKS_PER_BIT/2 (integer division). If high: false start, receiver returns to idle, no byte is produced.
  - Data bits are sampled every CLKS_PER_BIT cycles after that, LSB first; then the stop bit.
  - Stop sample high: `byte_valid` pulses for one cycle with the byte.
  - Stop sample low: `frame_err` pulses for one cycle instead.
- **Loader FSM**: IDLE, HDR0, HDR1, DATA, DONE, ERR.
  - IDLE: `cpu_hold`=0. A `load_en` rising edge goes to HDR0, clears `words_loaded` and the byte index. Received bytes are ignored.
  - HDR0: the first byte is the low byte of word count N.
  - HDR1: the next byte is the high byte of N.
    - N==0: go to DONE.
    - N > 2^ADDR_WIDTH: go to ERR.
    - Otherwise: go to DATA.
  - DATA: bytes assemble little-endian, so byte k of a word lands in bits [8k+7:8k].
    - On the 4th byte, pulse `mem_we` with `mem_addr`=`words_loaded`[ADDR_WIDTH-1:0] and the assembled `mem_wdata`.
    - `words_loaded` increments in the same cycle.
    - When `words_loaded` reaches N, go to DONE.
  - DONE: `done`=1, `cpu_hold`=0. A `load_en` rising edge restarts at HDR0.
  - ERR: `error`=1, `cpu_hold`=1, `mem_we`=0. When `load_en`==0, go to IDLE.
  - `frame_err` in HDR0, HDR1 or DATA goes to ERR. A partial word is discarded, never written.
- `cpu_hold` is 1 in HDR0, HDR1, DATA and ERR.
- `load_en` is a synchronous level. Its edge detector updates every cycle, so holding it high does not retrigger.

## Timing
- **Reset values**: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0, `done`=0, `error`=0, `words_loaded`=0. FSM in IDLE, receiver idle, synchronizer at 1.
- **Reset mid-load**: immediate abort to the reset values. Memory already written is untouched. `cpu_hold` drops asynchronously with reset.
- **Start edge**: `load_en` rising at cycle t puts the FSM in HDR0 at t+1, with `cpu_hold`=1 at t+1.
- **Byte timing**: `byte_valid` occurs 2 synchronizer cycles + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the rx falling edge at the pin, ±1 cycle.
- **Write strobe**: `mem_we`, `mem_addr` and `mem_wdata` are registered. They are valid in the cycle after the 4th `byte_valid` of a word.
- **End of load**: DONE (`done`=1, `cpu_hold`=0) is entered in the same cycle as the final `mem_we`. Memory sees the final write on the edge that ends that cycle.
- **Address range**: `mem_addr` never wraps. N is bounded by the header check, and N == 2^ADDR_WIDTH is legal (last address all-ones).
- **Extra bytes** received in DONE/IDLE are ignored.
- A `load_en` edge arriving while loading is ignored.

## Test plan
Use CLKS_PER_BIT=4 unless stated.
- **Reset**: `rst` high 3 cycles, rx idle -> all outputs 0, state IDLE; no `mem_we` for 200 cycles.
- **Basic load**: `load_en` edge, send 02 00 78 56 34 12 EF BE AD DE -> `mem_we` at addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF; `done`=1, `cpu_hold`=0, `words_loaded`=2.
- **Zero count**: header 00 00 -> DONE right after HDR1; no `mem_we`; `cpu_hold` high for exactly the header duration.
- **Framing error**: header 01 00, then 2 bytes, then a byte with stop=0 -> `error`=1, `cpu_hold`=1, no `mem_we`. Drop `load_en` -> IDLE next cycle, `error`=0.
- **Oversize count**: ADDR_WIDTH=4, header 11 00 (N=17) -> ERR. Header 10 00 (N=16) -> 16 writes, last at addr 0xF.
- **Glitch and async reset**: a 1-cycle low pulse on rx -> no byte. Assert `rst` mid-DATA after 1 word -> outputs reset immediately. Relaunch -> reload starts at addr 0.
